// File: rtl/bubble_read_seq_if.sv
// Handshake and status bundle between the host-side DMA/FIFO control,
// the rotation timing generator and the bubble read-page sequencer.
interface bubble_read_seq_if #(
  parameter int CNT_W = 12,
  parameter int DLY_W = 8
);
  logic             i_CLK2M_PCEN_n;
  logic [19:0]      i_ROT20_n;
  logic             i_4BEN_n;
  logic             i_RD_REQ;
  logic             i_ABORT;
  logic [DLY_W-1:0] i_DELAY;
  logic             o_BDI_EN_SET_n;
  logic             o_BDI_EN_RST_n;
  logic             o_BIT_STB;
  logic [CNT_W-1:0] o_BIT_CNT;
  logic             o_BUSY;
  logic             o_DONE;
  logic             o_ABORTED;

  // Host/timing side drives the request and phase inputs
  modport master (
    output i_CLK2M_PCEN_n, i_ROT20_n, i_4BEN_n, i_RD_REQ, i_ABORT, i_DELAY,
    input  o_BDI_EN_SET_n, o_BDI_EN_RST_n, o_BIT_STB, o_BIT_CNT,
           o_BUSY, o_DONE, o_ABORTED
  );

  // Sequencer side
  modport slave (
    input  i_CLK2M_PCEN_n, i_ROT20_n, i_4BEN_n, i_RD_REQ, i_ABORT, i_DELAY,
    output o_BDI_EN_SET_n, o_BDI_EN_RST_n, o_BIT_STB, o_BIT_CNT,
           o_BUSY, o_DONE, o_ABORTED
  );
endinterface

// File: rtl/bubble_read_seq.sv
// Read-page sequencer for the bubble read front-end. Aligns a page read to
// the 20-phase rotation, waits the access delay, brackets the page with the
// input-enable set/reset pulses and strobes each delivered serial bit.
// Every decision is made on the enabled edge that ends period k-1 so the
// resulting pulse is valid for the whole of period k.
module bubble_read_seq #(
  parameter int PAGE_BITS = 2048,
  parameter int CNT_W     = 12,
  parameter int DLY_W     = 8
) (
  input  logic              i_MCLK,
  input  logic              i_SYS_RST_n,
  bubble_read_seq_if.slave  bus
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ALIGN  = 3'd2;
  localparam logic [2:0] ST_DELAY  = 3'd3;
  localparam logic [2:0] ST_STREAM = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ABORT  = 3'd6;

  localparam logic [CNT_W-1:0] PAGE_CNT = CNT_W'(PAGE_BITS);
  localparam logic [4:0]       PH_NONE  = 5'd31;

  logic [2:0]       state, state_nxt;
  logic [DLY_W-1:0] dly_cnt, dly_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic             four_bit, four_nxt;
  logic             set_n, set_nxt;
  logic             rst_n, rst_nxt;
  logic             stb, stb_nxt;
  logic             busy;
  logic             done, done_nxt;
  logic             aborted, abt_nxt;

  logic [4:0]       phase;
  logic             en;
  logic             pre19;
  logic             pre_stb;
  logic             page_full;

  assign en        = ~bus.i_CLK2M_PCEN_n;
  assign pre19     = (phase == 5'd18);
  assign page_full = (bit_cnt == PAGE_CNT);
  assign pre_stb   = (phase == 5'd1) || (phase == 5'd6) ||
                     (four_bit && ((phase == 5'd11) || (phase == 5'd16)));

  // Encode the active-low one-hot rotation into a phase index; no phase low reads as PH_NONE
  always_comb begin
    phase = PH_NONE;
    for (int k = 0; k < 20; k++) begin
      if (!bus.i_ROT20_n[k]) phase = 5'(k);
    end
  end

  // Next-state and next-pulse decisions for the period that follows the current edge
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    cnt_nxt   = bit_cnt;
    four_nxt  = four_bit;
    set_nxt   = 1'b1;
    rst_nxt   = 1'b1;
    stb_nxt   = 1'b0;
    done_nxt  = 1'b0;
    abt_nxt   = 1'b0;
    case (state)
      ST_INIT: begin
        if (!rst_n) begin
          state_nxt = ST_IDLE;
        end else if (pre19) begin
          rst_nxt = 1'b0;
        end
      end
      ST_IDLE: begin
        if (bus.i_RD_REQ && !bus.i_ABORT) begin
          state_nxt = ST_ALIGN;
          dly_nxt   = bus.i_DELAY;
          cnt_nxt   = '0;
          four_nxt  = ~bus.i_4BEN_n;
        end
      end
      ST_ALIGN, ST_DELAY: begin
        if (bus.i_ABORT) begin
          rst_nxt   = 1'b0;
          abt_nxt   = 1'b1;
          state_nxt = ST_ABORT;
        end else if (pre19) begin
          if ((state == ST_ALIGN && dly_cnt == '0) ||
              (state == ST_DELAY && dly_cnt == DLY_W'(1))) begin
            set_nxt   = 1'b0;
            state_nxt = ST_STREAM;
          end else if (state == ST_ALIGN) begin
            state_nxt = ST_DELAY;
          end else begin
            dly_nxt = dly_cnt - DLY_W'(1);
          end
        end
      end
      ST_STREAM: begin
        if (bus.i_ABORT) begin
          rst_nxt   = 1'b0;
          abt_nxt   = 1'b1;
          state_nxt = ST_ABORT;
        end else begin
          if (stb) cnt_nxt = bit_cnt + CNT_W'(1);
          if (pre19 && page_full) begin
            rst_nxt   = 1'b0;
            state_nxt = ST_DONE;
          end else if (pre_stb && !page_full) begin
            stb_nxt = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (done) begin
          state_nxt = ST_IDLE;
        end else begin
          done_nxt = 1'b1;
        end
      end
      ST_ABORT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Register state and all outputs on enabled edges only; reset restarts the INIT sequence
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      state    <= ST_INIT;
      dly_cnt  <= '0;
      bit_cnt  <= '0;
      four_bit <= 1'b0;
      set_n    <= 1'b1;
      rst_n    <= 1'b1;
      stb      <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else if (en) begin
      state    <= state_nxt;
      dly_cnt  <= dly_nxt;
      bit_cnt  <= cnt_nxt;
      four_bit <= four_nxt;
      set_n    <= set_nxt;
      rst_n    <= rst_nxt;
      stb      <= stb_nxt;
      busy     <= (state_nxt != ST_IDLE);
      done     <= done_nxt;
      aborted  <= abt_nxt;
    end
  end

  assign bus.o_BDI_EN_SET_n = set_n;
  assign bus.o_BDI_EN_RST_n = rst_n;
  assign bus.o_BIT_STB      = stb;
  assign bus.o_BIT_CNT      = bit_cnt;
  assign bus.o_BUSY         = busy;
  assign bus.o_DONE         = done;
  assign bus.o_ABORTED      = aborted;

endmodule

// File: doc/bubble_read_seq.md
Name: bubble_read_seq

Overview:
- Read-page sequencer for the bubble read front-end.
- On request, it aligns to the 20-phase rotation and waits a programmable access delay in rotations.
- It then pulses the front-end input-enable set, counts delivered bits to the page length, and pulses input-enable reset.
- It sits between the host-side DMA/FIFO control and the read front-end. It supplies per-bit strobes and a running bit count to the deserialiser.

Parameters:
- PAGE_BITS, 2048, bits per page; multiple of 4, at least 4.
- CNT_W, 12, bit-counter width; must satisfy 2^CNT_W > PAGE_BITS.
- DLY_W, 8, width of the access-delay input.

Ports:
- i_MCLK  in  1  master clock.
- i_SYS_RST_n  in  1  system reset; asynchronous, active-low.
- i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active-low; all state advances only on i_MCLK edges with this low.
- i_ROT20_n  in  20  rotation phase, one-hot active-low; bit k low means phase k.
- i_4BEN_n  in  1  0 = 4 bits per rotation, 1 = 2 bits per rotation.
- i_RD_REQ  in  1  start page read; level, sampled in IDLE.
- i_ABORT  in  1  abort the current read; level.
- i_DELAY  in  DLY_W  access delay in whole rotations; sampled at request accept.
- o_BDI_EN_SET_n  out  1  front-end input-enable set pulse, active-low.
- o_BDI_EN_RST_n  out  1  front-end input-enable reset pulse, active-low.
- o_BIT_STB  out  1  high for one enable period per valid serial bit.
- o_BIT_CNT  out  CNT_W  bits delivered in the current page.
- o_BUSY  out  1  high in every state except IDLE.
- o_DONE  out  1  one enable-period pulse at normal page completion.
- o_ABORTED  out  1  one enable-period pulse when an abort is taken.

Behaviour:
- All outputs are registered and update only on enabled edges; async reset overrides.
- Reset values:
  - SET_n = 1, RST_n = 1, BIT_STB = 0, BIT_CNT = 0, BUSY = 1, DONE = 0, ABORTED = 0.
  - State = INIT.
- "Period k" means the enable period in which i_ROT20_n[k] == 0.
- Pulse outputs are launched on the enabled edge that ends period k-1, so they are valid throughout period k.
- INIT:
  - Emit one RST_n low pulse in the first period 19 after reset release; the front-end enable is indeterminate after reset.
  - Then go to IDLE (BUSY = 0).
- IDLE:
  - When i_RD_REQ = 1 on an enabled edge: latch i_DELAY into the delay counter, clear BIT_CNT, and go to ALIGN.
  - If i_ABORT = 1 on the same edge, abort wins: the request is dropped and ABORTED is not pulsed.
- ALIGN:
  - Wait for period 19.
  - If the delay counter is 0, drive SET_n low in this period 19 and go to STREAM. The enable is then active from period 0, coinciding with the front-end mux reset.
  - Otherwise go to DELAY.
- DELAY:
  - Decrement the delay counter at each period 19.
  - In the period 19 where the counter reads 1, drive SET_n low and go to STREAM.
  - Total wait is exactly i_DELAY full rotations before the first streamed rotation.
- STREAM strobes:
  - 4-bit mode: BIT_STB = 1 in periods 2, 7, 12, 17.
  - 2-bit mode: BIT_STB = 1 in periods 2 and 7 only.
  - These are the last period each mux position is stable.
  - i_4BEN_n is sampled at request accept and held for the whole page; mid-page changes are ignored.
- STREAM counting:
  - BIT_CNT increments on the edge ending each strobe period.
  - When BIT_CNT reaches PAGE_BITS, no further strobes are issued.
  - At the next period 19, drive RST_n low and go to DONE.
- DONE:
  - DONE = 1 for one enable period (period 0), then IDLE.
  - BIT_CNT holds PAGE_BITS until the next request is accepted.
- Abort: i_ABORT = 1 in ALIGN, DELAY or STREAM on an enabled edge causes the following, regardless of phase:
  - RST_n low for the next enable period.
  - ABORTED = 1 in that same period.
  - BIT_STB forced 0 and BIT_CNT frozen.
  - Then IDLE.
- Abort and completion on the same edge: abort wins; DONE is not pulsed.
- i_RD_REQ is ignored outside IDLE. A level held high through DONE starts a new page on the first enabled edge in IDLE.
- SET_n and RST_n are never low in the same period.
- Neither pulse is ever low for more than one enable period.
- Edges with i_CLK2M_PCEN_n = 1 leave all state and outputs unchanged.
- Reset asserted mid-page: immediate return to reset values, then the INIT sequence.

Test Plan:
- Reset release, then idle → one RST_n pulse in the first period 19; BUSY falls to 0 at the next enabled edge; SET_n stays 1.
- 4-bit mode, DELAY = 0, PAGE_BITS = 2048 → SET_n low in the first period 19 after request; 2048 BIT_STB pulses over 512 rotations at phases 2/7/12/17; RST_n low in the final period 19; DONE in the following period 0; BIT_CNT = 2048.
- 2-bit mode, DELAY = 3 → SET_n exactly 3 rotations after the first period 19; strobes only at phases 2/7; 1024 rotations to completion.
- Abort asserted in STREAM at BIT_CNT = 100 → RST_n and ABORTED low/high in the next period; BIT_CNT holds 100; no DONE; BUSY = 0.
- i_RD_REQ and i_ABORT both high in IDLE → remains IDLE; no SET_n or ABORTED pulse.
- i_CLK2M_PCEN_n held high for 50 MCLK mid-stream, then async reset mid-page → no state change while disabled; on reset, all outputs immediately take reset values, followed by the INIT RST_n pulse.
